// File: rtl/ds_box2x2.sv
// ds_box2x2 -- 2x2 box-filter downsampler for a raster-order RGB pixel stream.
//
// Every non-overlapping 2x2 block of the input image becomes one output pixel
// whose channels are the floor average of the four input channels. The output
// image is IMG_W/2 x IMG_H/2, addressed linearly in raster order.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   pix_i         input pixel {R[23:16], G[15:8], B[7:0]}, sampled when pix_valid_i=1
//   pix_valid_i   input valid; gaps of any length are allowed, no backpressure
//   frame_clr_i   synchronous frame restart (like reset, line buffer untouched,
//                 ds_pix_o/ds_addr_o keep their values)
//   ds_pix_o      averaged output pixel, held while ds_valid_o=0
//   ds_valid_o    one-cycle pulse per output pixel, 1 cycle after the
//                 completing (odd row, odd col) input pixel
//   ds_addr_o     linear output index (row/2)*(IMG_W/2)+(col/2), held
//   frame_done_o  one-cycle pulse coincident with the last output of a frame
//
// Only DATA_WIDTH=24 is supported. IMG_W and IMG_H must be even and >= 2.

module ds_box2x2 #(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 16,
   parameter int IMG_W      = 256,
   parameter int IMG_H      = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] pix_i,
   input  logic                  pix_valid_i,
   input  logic                  frame_clr_i,
   output logic [DATA_WIDTH-1:0] ds_pix_o,
   output logic                  ds_valid_o,
   output logic [ADDR_WIDTH-1:0] ds_addr_o,
   output logic                  frame_done_o
);

   localparam int CW       = $clog2(IMG_W);
   localparam int RW       = $clog2(IMG_H);
   localparam int LB_DEPTH = IMG_W / 2;
   localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int NOUT     = (IMG_W / 2) * (IMG_H / 2);

   localparam logic [CW-1:0]         COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_H - 1);
   localparam logic [ADDR_WIDTH-1:0] OUT_LAST = ADDR_WIDTH'(NOUT - 1);

   // Position of the current pixel inside its 2x2 block: {row[0], col[0]}.
   typedef enum logic [1:0] {
      PH_EVEN_EVEN = 2'b00,
      PH_EVEN_ODD  = 2'b01,
      PH_ODD_EVEN  = 2'b10,
      PH_ODD_ODD   = 2'b11
   } phase_t;

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [DATA_WIDTH-1:0] held;
   logic [ADDR_WIDTH-1:0] out_cnt;

   // Line buffer: one 27-bit entry per horizontal pair, {R9, G9, B9}.
   logic [26:0]           linebuf [LB_DEPTH];
   logic [LBW-1:0]        lb_idx;
   logic [26:0]           lb_rd;

   phase_t                phase;
   logic                  col_last;
   logic                  row_last;
   logic                  out_last;
   logic [26:0]           pair_sum;
   logic [DATA_WIDTH-1:0] avg_pix;
   logic                  accept;

   logic [8:0]            pr_r, pr_g, pr_b;
   logic [9:0]            qs_r, qs_g, qs_b;

   assign accept   = pix_valid_i && !frame_clr_i;
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);
   assign out_last = (out_cnt == OUT_LAST);
   assign lb_idx   = LBW'(col >> 1);
   assign lb_rd    = linebuf[lb_idx];

   always_comb begin
      phase    = phase_t'({row[0], col[0]});

      // Horizontal pair sum for even rows (9 bits per channel).
      pr_r     = 9'(held[23:16]) + 9'(pix_i[23:16]);
      pr_g     = 9'(held[15:8])  + 9'(pix_i[15:8]);
      pr_b     = 9'(held[7:0])   + 9'(pix_i[7:0]);
      pair_sum = {pr_r, pr_g, pr_b};

      // Upper pair from the line buffer plus lower pair; 4*255 fits in 10 bits.
      qs_r     = 10'(lb_rd[26:18]) + 10'(held[23:16]) + 10'(pix_i[23:16]);
      qs_g     = 10'(lb_rd[17:9])  + 10'(held[15:8])  + 10'(pix_i[15:8]);
      qs_b     = 10'(lb_rd[8:0])   + 10'(held[7:0])   + 10'(pix_i[7:0]);
      avg_pix  = {qs_r[9:2], qs_g[9:2], qs_b[9:2]};
   end

   // Line buffer storage has no reset: each entry is written on the even row
   // before the odd row of the same block pair reads it.
   always_ff @(posedge clk) begin
      if (rst_n && accept && (phase == PH_EVEN_ODD)) begin
         linebuf[lb_idx] <= pair_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col          <= '0;
         row          <= '0;
         held         <= '0;
         out_cnt      <= '0;
         ds_pix_o     <= '0;
         ds_valid_o   <= 1'b0;
         ds_addr_o    <= '0;
         frame_done_o <= 1'b0;
      end else if (frame_clr_i) begin
         // Restart the frame; a pixel presented alongside the clear is dropped.
         col          <= '0;
         row          <= '0;
         held         <= '0;
         out_cnt      <= '0;
         ds_valid_o   <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         ds_valid_o   <= 1'b0;
         frame_done_o <= 1'b0;
         if (pix_valid_i) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end

            unique case (phase)
               PH_EVEN_EVEN, PH_ODD_EVEN: begin
                  held <= pix_i;
               end
               PH_EVEN_ODD: begin
                  // Pair sum goes to the line buffer in the block above.
               end
               PH_ODD_ODD: begin
                  ds_pix_o     <= avg_pix;
                  ds_valid_o   <= 1'b1;
                  ds_addr_o    <= out_cnt;
                  frame_done_o <= out_last;
                  out_cnt      <= out_last ? '0 : out_cnt + 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ds_box2x2.sv
// Self-checking bench for ds_box2x2 on a 4x4 image.
// A frame-level reference model records accepted pixels into an image array
// and, when a 2x2 block is complete, queues the block average, its address
// and the edge at which the DUT must present it.

module tb_ds_box2x2;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] pix_i = '0;
   logic        pix_valid_i = 1'b0;
   logic        frame_clr_i = 1'b0;
   logic [23:0] ds_pix_o;
   logic        ds_valid_o;
   logic [15:0] ds_addr_o;
   logic        frame_done_o;

   ds_box2x2 #(
      .DATA_WIDTH(24),
      .ADDR_WIDTH(16),
      .IMG_W(W),
      .IMG_H(H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pix_i(pix_i),
      .pix_valid_i(pix_valid_i),
      .frame_clr_i(frame_clr_i),
      .ds_pix_o(ds_pix_o),
      .ds_valid_o(ds_valid_o),
      .ds_addr_o(ds_addr_o),
      .frame_done_o(frame_done_o)
   );

   always #5 clk = ~clk;

   int unsigned edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic mon_on = 1'b0;

   typedef struct {
      logic [23:0] pix;
      logic [15:0] addr;
      logic        done;
      int unsigned due;
   } exp_t;

   exp_t expq[$];

   typedef struct {
      logic [23:0] p [4];
      logic [23:0] exp;
   } vec_t;

   vec_t        tbl [6];
   logic [23:0] img [H][W];
   logic [23:0] frm [W*H];
   int          mrow = 0;
   int          mcol = 0;

   function automatic logic [23:0] avg4(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c, input logic [23:0] d);
      logic [23:0] r;
      int s;
      r = '0;
      for (int k = 0; k < 3; k++) begin
         s = int'(a[k*8 +: 8]) + int'(b[k*8 +: 8]) + int'(c[k*8 +: 8]) + int'(d[k*8 +: 8]);
         r[k*8 +: 8] = 8'(s / 4);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Apply one cycle of inputs and update the reference model.
   task automatic drive(input logic [23:0] p, input logic v, input logic clr, input logic rn);
      exp_t e;
      pix_i       = p;
      pix_valid_i = v;
      frame_clr_i = clr;
      rst_n       = rn;
      if (!rn || clr) begin
         mrow = 0;
         mcol = 0;
      end else if (v) begin
         img[mrow][mcol] = p;
         if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
            e.pix  = avg4(img[mrow-1][mcol-1], img[mrow-1][mcol], img[mrow][mcol-1], p);
            e.addr = 16'((mrow / 2) * (W / 2) + mcol / 2);
            e.done = (mrow == H - 1) && (mcol == W - 1);
            e.due  = edge_n + 1;
            expq.push_back(e);
         end
         mcol++;
         if (mcol == W) begin
            mcol = 0;
            mrow++;
            if (mrow == H) mrow = 0;
         end
      end
      @(posedge clk);
      #1;
      pix_valid_i = 1'b0;
      frame_clr_i = 1'b0;
      rst_n       = 1'b1;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) drive(24'($urandom), 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_frame(input int unsigned maxgap);
      for (int i = 0; i < W*H; i++) begin
         idle((maxgap == 0) ? 0 : $urandom_range(maxgap, 0));
         drive(frm[i], 1'b1, 1'b0, 1'b1);
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < W*H; i++) frm[i] = 24'($urandom);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         if (frame_done_o) done_cnt++;
         if (expq.size() != 0 && expq[0].due == edge_n) begin
            e = expq.pop_front();
            check("ds_valid_o", 32'(ds_valid_o), 32'd1);
            check("ds_pix_o", 32'(ds_pix_o), 32'(e.pix));
            check("ds_addr_o", 32'(ds_addr_o), 32'(e.addr));
            check("frame_done_o", 32'(frame_done_o), 32'(e.done));
         end else if (ds_valid_o || frame_done_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_output: valid=%b done=%b, expected both 0 (t=%0t)",
                     ds_valid_o, frame_done_o, $time);
         end
      end
   end

   initial begin
      int d0;

      tbl[0].p = '{24'h804020, 24'h804020, 24'h804020, 24'h804020}; tbl[0].exp = 24'h804020;
      tbl[1].p = '{24'h01ff00, 24'h01ff00, 24'h01ff00, 24'h02ff03}; tbl[1].exp = 24'h01ff00;
      tbl[2].p = '{24'hffffff, 24'hffffff, 24'hffffff, 24'hffffff}; tbl[2].exp = 24'hffffff;
      tbl[3].p = '{24'h000000, 24'h000000, 24'h000000, 24'h000000}; tbl[3].exp = 24'h000000;
      tbl[4].p = '{24'h010203, 24'h040506, 24'h070809, 24'h0a0b0c}; tbl[4].exp = 24'h050607;
      tbl[5].p = '{24'hffffff, 24'hffffff, 24'hffffff, 24'hfefefe}; tbl[5].exp = 24'hfefefe;

      repeat (3) drive(24'h123456, 1'b1, 1'b0, 1'b0);
      check("reset_pix", 32'(ds_pix_o), 32'd0);
      check("reset_valid", 32'(ds_valid_o), 32'd0);
      check("reset_addr", 32'(ds_addr_o), 32'd0);
      check("reset_done", 32'(frame_done_o), 32'd0);
      mon_on = 1'b1;

      // Table: each block pattern tiled over a whole frame.
      for (int t = 0; t < 6; t++) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               frm[r*W + c] = tbl[t].p[(r % 2) * 2 + (c % 2)];
         d0 = done_cnt;
         send_frame((t % 2 == 0) ? 0 : 3);
         idle(2);
         check("tbl_pix", 32'(ds_pix_o), 32'(tbl[t].exp));
         check("tbl_addr", 32'(ds_addr_o), 32'd3);
         check("tbl_frame_done_count", 32'(done_cnt - d0), 32'd1);
      end

      // Constant frame with random idle gaps.
      for (int i = 0; i < W*H; i++) frm[i] = 24'h804020;
      send_frame(3);
      idle(2);

      // Back-to-back frames with distinct contents.
      d0 = done_cnt;
      rand_frame();
      send_frame(0);
      rand_frame();
      send_frame(0);
      idle(2);
      check("b2b_frame_done_count", 32'(done_cnt - d0), 32'd2);

      // Clear after 6 pixels: pixel 5 completes block 0 normally, the pixel
      // presented with the clear is dropped, the next frame restarts at 0.
      rand_frame();
      for (int i = 0; i < 6; i++) drive(frm[i], 1'b1, 1'b0, 1'b1);
      drive(24'habcdef, 1'b1, 1'b1, 1'b1);
      check("clr_valid_next", 32'(ds_valid_o), 32'd0);
      rand_frame();
      send_frame(0);
      idle(2);

      // Reset arriving with the completing pixel of the last block.
      rand_frame();
      for (int i = 0; i < W*H - 1; i++) drive(frm[i], 1'b1, 1'b0, 1'b1);
      drive(frm[W*H-1], 1'b1, 1'b0, 1'b0);
      check("rst_mid_pix", 32'(ds_pix_o), 32'd0);
      check("rst_mid_valid", 32'(ds_valid_o), 32'd0);
      check("rst_mid_addr", 32'(ds_addr_o), 32'd0);
      check("rst_mid_done", 32'(frame_done_o), 32'd0);
      rand_frame();
      send_frame(0);
      idle(2);

      // Random frames with random gaps, some aborted part-way by a clear.
      for (int f = 0; f < 16; f++) begin
         rand_frame();
         if (f % 4 == 3) begin
            for (int i = 0; i < int'($urandom_range(15, 1)); i++) begin
               idle($urandom_range(2, 0));
               drive(frm[i], 1'b1, 1'b0, 1'b1);
            end
            drive(24'($urandom), 1'($urandom), 1'b1, 1'b1);
         end else begin
            send_frame($urandom_range(3, 0));
         end
      end

      idle(4);
      check("expected_queue_drained", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
